program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//   Boot-time writer for the instruction ROM: the other end of the fetch-side read port that PC/IF uses.
//   Receives a byte stream (e.g. from a UART receiver) and assembles little-endian 32-bit words.
//   Writes the words to consecutive word-aligned ROM byte addresses starting at 0.
//   Holds the CPU in reset until the load completes, then releases it.
// PARAMETERS
//   ADDR_WIDTH   12   ROM byte-address width; capacity = 2**(ADDR_WIDTH-2) words
// PORTS
//   clk              in   1           system clock, all state on rising edge
//   reset_n          in   1           asynchronous, active-low reset
//   rx_data          in   8           received byte
//   rx_valid         in   1           1-cycle strobe: rx_data valid this cycle
//   rom_wren         out  1           ROM write strobe, one cycle per word
//   rom_address      out  ADDR_WIDTH  ROM byte address, word-aligned ([1:0]=0)
//   rom_write_data   out  32          ROM write word
//   cpu_reset_n      out  1           reset to the CPU; 0 while loading or on error
//   loading          out  1           1 in RECV_LEN/RECV_DATA
//   done             out  1           1 in DONE (sticky)
//   error            out  1           1 in ERROR (sticky)
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (clk, reset_n).
// - Reset: all outputs 0; state RECV_LEN; byte_cnt=0, word_cnt=0, shift reg=0.
// - Frame format: 4-byte length N (LSB first), then N words, each 4 bytes LSB first.
// - Byte assembly: on rx_valid, shift_reg <= {rx_data, shift_reg[31:8]}; byte_cnt increments mod 4.
// - RECV_LEN:
//   - 4th byte accepted: len <= assembled word; next state:
//     - N==0 -> DONE;
//     - N > 2**(ADDR_WIDTH-2) -> ERROR;
//     - else -> RECV_DATA.
// - RECV_DATA:
//   - 4th byte of word k accepted at cycle t: at t+1 rom_wren=1, rom_address=k*4, rom_write_data=word.
//   - When k==N-1, state -> DONE at t+1 (same edge as the write pulse).
// - rom_wren is 0 in every other cycle.
// - rom_address/rom_write_data hold their last values when rom_wren=0.
// - DONE: cpu_reset_n=1, done=1; occurs 1 cycle after the last write strobe, or 1 cycle after the length for N==0.
//   rx_valid is ignored.
// - ERROR: cpu_reset_n=0, error=1; rx_valid ignored; leave only via reset_n.
// - loading is registered: 1 from the first clk edge after reset release until DONE/ERROR.
// - rx_valid on consecutive cycles must be accepted without loss.
//   Max throughput is 1 byte/clk; back-to-back words give a write every 4 cycles.
// - Gaps between bytes of any length are allowed; there is no timeout.
// - Address arithmetic: word_cnt is ADDR_WIDTH-2 bits.
//   rom_address = {word_cnt, 2'b00}; N equal to capacity is legal and fills the ROM exactly (no wrap).
// - Reset mid-load: everything returns to reset values; the partial ROM contents are not cleared.
//   The next frame restarts at address 0.
// - ROM contract: a registered write port on rom_wren; the CPU read port is independent and unused while cpu_reset_n=0.
// TESTING
// - Reset, then bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00:
//   - writes (0x0,0x00000013), (0x4,0x00100093), each a 1-cycle rom_wren;
//   - done=1 and cpu_reset_n=1 exactly 1 cycle after the 2nd write.
// - Length 00 00 00 00 -> no rom_wren; done=1 and cpu_reset_n=1 on the cycle after the 4th byte.
// - ADDR_WIDTH=4, length 05 00 00 00 -> error=1, cpu_reset_n=0; following bytes give no rom_wren.
// - ADDR_WIDTH=4, length 4, 16 back-to-back bytes -> 4 writes at addresses 0x0,0x4,0x8,0xC spaced 4 cycles; done.
// - Random 0-20 cycle gaps between bytes, N=8 -> data/addresses identical to the gap-free run.
// - reset_n low after 6 bytes of a frame, then a new N=1 frame -> a single write at address 0x0 with the new word.

Source files
------------

// File: rtl/program_loader_if.sv
// ============================================================================
// Module   : program_loader_if
// Brief    : Byte-stream input and ROM write/CPU control bundle of the loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface program_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rom_wren;
    logic [ADDR_WIDTH-1:0] rom_address;
    logic [31:0]           rom_write_data;
    logic                  cpu_reset_n;
    logic                  loading;
    logic                  done;
    logic                  error;

    // Byte source / ROM / CPU side.
    modport master (
        output rx_data,
        output rx_valid,
        input  rom_wren,
        input  rom_address,
        input  rom_write_data,
        input  cpu_reset_n,
        input  loading,
        input  done,
        input  error
    );

    // Loader side.
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rom_wren,
        output rom_address,
        output rom_write_data,
        output cpu_reset_n,
        output loading,
        output done,
        output error
    );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Brief    : Boot loader assembling a length-prefixed LE byte stream into
//            instruction-ROM words; holds the CPU in reset until complete.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int ADDR_WIDTH = 12
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    program_loader_if.slave bus
);
    localparam int          c_word_w   = ADDR_WIDTH - 2;
    localparam int          c_len_w    = ADDR_WIDTH - 1;
    localparam logic [31:0] c_capacity = 32'(1) << c_word_w;

    typedef enum logic [1:0] {
        S_RECV_LEN  = 2'd0,
        S_RECV_DATA = 2'd1,
        S_DONE      = 2'd2,
        S_ERROR     = 2'd3
    } state_t;

    state_t                r_state;
    logic [23:0]           r_shift;
    logic [1:0]            r_byte_cnt;
    logic [c_word_w-1:0]   r_word_cnt;
    logic [c_len_w-1:0]    r_len;
    logic                  r_rom_wren;
    logic [ADDR_WIDTH-1:0] r_rom_address;
    logic [31:0]           r_rom_write_data;
    logic                  r_cpu_reset_n;
    logic                  r_loading;
    logic                  r_done;
    logic                  r_error;

    logic [31:0] w_word;
    logic        w_word_done;
    logic        w_last_word;

    // Only the upper three bytes of history are kept; the incoming byte completes the word.
    assign w_word      = {bus.rx_data, r_shift};
    assign w_word_done = bus.rx_valid && (r_byte_cnt == 2'd3);
    assign w_last_word = ({1'b0, r_word_cnt} == (r_len - c_len_w'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_RECV_LEN;
            r_shift          <= '0;
            r_byte_cnt       <= '0;
            r_word_cnt       <= '0;
            r_len            <= '0;
            r_rom_wren       <= 1'b0;
            r_rom_address    <= '0;
            r_rom_write_data <= '0;
            r_cpu_reset_n    <= 1'b0;
            r_loading        <= 1'b0;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
        end else begin
            r_rom_wren <= 1'b0;
            if (bus.rx_valid && (r_state == S_RECV_LEN || r_state == S_RECV_DATA)) begin
                r_shift    <= w_word[31:8];
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            case (r_state)
                S_RECV_LEN: begin
                    r_loading <= 1'b1;
                    if (w_word_done) begin
                        r_len <= w_word[c_len_w-1:0];
                        if (w_word == 32'd0) begin
                            // Empty program: release the CPU straight away.
                            r_state       <= S_DONE;
                            r_loading     <= 1'b0;
                            r_done        <= 1'b1;
                            r_cpu_reset_n <= 1'b1;
                        end else if (w_word > c_capacity) begin
                            r_state   <= S_ERROR;
                            r_loading <= 1'b0;
                            r_error   <= 1'b1;
                        end else begin
                            r_state <= S_RECV_DATA;
                        end
                    end
                end
                S_RECV_DATA: begin
                    r_loading <= 1'b1;
                    if (w_word_done) begin
                        r_rom_wren       <= 1'b1;
                        r_rom_address    <= {r_word_cnt, 2'b00};
                        r_rom_write_data <= w_word;
                        r_word_cnt       <= r_word_cnt + 1'b1;
                        if (w_last_word) begin
                            r_state   <= S_DONE;
                            r_loading <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_loading     <= 1'b0;
                    r_done        <= 1'b1;
                    r_cpu_reset_n <= 1'b1;
                end
                S_ERROR: begin
                    r_loading     <= 1'b0;
                    r_error       <= 1'b1;
                    r_cpu_reset_n <= 1'b0;
                end
                default: r_state <= S_ERROR;
            endcase
        end
    end

    assign bus.rom_wren       = r_rom_wren;
    assign bus.rom_address    = r_rom_address;
    assign bus.rom_write_data = r_rom_write_data;
    assign bus.cpu_reset_n    = r_cpu_reset_n;
    assign bus.loading        = r_loading;
    assign bus.done           = r_done;
    assign bus.error          = r_error;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Brief    : Directed + randomised bench for program_loader (ADDR_WIDTH 12 and 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;
    typedef struct packed {
        logic [31:0] cyc;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst12_n = 1'b0;
    logic       rst4_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    int         cyc = 0;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] frame[$];
    wr_t        wq12[$];
    wr_t        wq4[$];
    int         done12_cyc = -1;
    int         done4_cyc = -1;
    logic       done12_q = 1'b0;
    logic       done4_q = 1'b0;

    program_loader_if #(.ADDR_WIDTH(12)) bus12 ();
    program_loader_if #(.ADDR_WIDTH(4))  bus4 ();

    assign bus12.rx_data  = rx_data;
    assign bus12.rx_valid = rx_valid;
    assign bus4.rx_data   = rx_data;
    assign bus4.rx_valid  = rx_valid;

    program_loader #(.ADDR_WIDTH(12)) dut12 (.clk(clk), .reset_n(rst12_n), .bus(bus12));
    program_loader #(.ADDR_WIDTH(4))  dut4  (.clk(clk), .reset_n(rst4_n),  .bus(bus4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus12.rom_wren) wq12.push_back({32'(cyc), bus12.rom_address, bus12.rom_write_data});
        if (bus4.rom_wren)  wq4.push_back({32'(cyc), {8'h00, bus4.rom_address}, bus4.rom_write_data});
        if (bus12.done && !done12_q && done12_cyc < 0) done12_cyc = cyc;
        if (bus4.done && !done4_q && done4_cyc < 0)    done4_cyc = cyc;
        done12_q = bus12.done;
        done4_q  = bus4.done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input bit use4, input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        if (use4) obs = {bus4.rom_wren, |bus4.rom_address, |bus4.rom_write_data,
                         bus4.cpu_reset_n, bus4.loading, bus4.done, bus4.error};
        else      obs = {bus12.rom_wren, |bus12.rom_address, |bus12.rom_write_data,
                         bus12.cpu_reset_n, bus12.loading, bus12.done, bus12.error};
        check(tag, 64'(obs), 64'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    // Reset both DUTs, then release only the one under test.
    task automatic do_reset(input bit use4, input string tag);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rst12_n  = 1'b0;
        rst4_n   = 1'b0;
        #1;
        check_outs(use4, {tag, "_rst_outs"}, 7'b0);
        @(posedge clk); #1;
        if (use4) rst4_n = 1'b1;
        else      rst12_n = 1'b1;
        check_outs(use4, {tag, "_rel_outs"}, 7'b0);
        @(posedge clk); #1;
        check_outs(use4, {tag, "_first_edge"}, 7'b0000100);
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) frame.push_back(w[8*i +: 8]);
    endtask

    // Send the frame in `frame`, then compare against the frame-level model.
    task automatic run_frame(input bit use4, input int max_gap, input int n_extra, input string tag);
        int          bcyc[$];
        wr_t         got[$];
        logic [31:0] n;
        logic [31:0] word;
        int          cap;
        int          exp_done;
        bit          ld;
        bit          cr;

        cap = use4 ? 4 : 1024;
        wq12.delete();
        wq4.delete();
        done12_cyc = -1;
        done4_cyc  = -1;
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
            bcyc.push_back(cyc);
            if (i == 1) begin
                ld = use4 ? bus4.loading : bus12.loading;
                cr = use4 ? bus4.cpu_reset_n : bus12.cpu_reset_n;
                check({tag, "_mid_loading"}, 64'(ld), 64'd1);
                check({tag, "_mid_cpu_reset_n"}, 64'(cr), 64'd0);
            end
        end
        for (int i = 0; i < n_extra; i++) send_byte(8'($urandom), 0);
        idle(6);

        if (use4) got = wq4;
        else      got = wq12;
        n = {frame[3], frame[2], frame[1], frame[0]};
        if (n > 32'(cap)) begin
            check({tag, "_nwrites"}, 64'(got.size()), 64'd0);
            check_outs(use4, {tag, "_err_outs"}, 7'b0000001);
        end else begin
            check({tag, "_nwrites"}, 64'(got.size()), 64'(n));
            for (int k = 0; k < int'(n) && k < got.size(); k++) begin
                word = {frame[4*k+7], frame[4*k+6], frame[4*k+5], frame[4*k+4]};
                check($sformatf("%s_addr%0d", tag, k), 64'(got[k].addr), 64'(k * 4));
                check($sformatf("%s_data%0d", tag, k), 64'(got[k].data), 64'(word));
                check($sformatf("%s_wcyc%0d", tag, k), 64'(got[k].cyc), 64'(bcyc[4*k+7] + 1));
            end
            exp_done = (n == 0) ? bcyc[3] + 1 : bcyc[4*n+3] + 2;
            check({tag, "_done_cyc"}, 64'(use4 ? done4_cyc : done12_cyc), 64'(exp_done));
            ld = use4 ? bus4.done : bus12.done;
            cr = use4 ? bus4.cpu_reset_n : bus12.cpu_reset_n;
            check({tag, "_done"}, 64'(ld), 64'd1);
            check({tag, "_cpu_reset_n"}, 64'(cr), 64'd1);
            check({tag, "_error"}, 64'(use4 ? bus4.error : bus12.error), 64'd0);
        end
        check({tag, "_loading_end"}, 64'(use4 ? bus4.loading : bus12.loading), 64'd0);
    endtask

    initial begin
        logic [31:0] rnd[$];

        // Two-word directed program.
        do_reset(1'b0, "t2w");
        frame.delete();
        add_word(32'd2); add_word(32'h0000_0013); add_word(32'h0010_0093);
        run_frame(1'b0, 0, 4, "t2w");

        // Empty program.
        do_reset(1'b0, "t0");
        frame.delete();
        add_word(32'd0);
        run_frame(1'b0, 0, 6, "t0");

        // Eight random words, gap-free then with random gaps.
        for (int i = 0; i < 8; i++) rnd.push_back($urandom);
        do_reset(1'b0, "t8");
        frame.delete();
        add_word(32'd8);
        foreach (rnd[i]) add_word(rnd[i]);
        run_frame(1'b0, 0, 0, "t8");
        do_reset(1'b0, "t8g");
        run_frame(1'b0, 20, 0, "t8g");

        // Reset after six bytes, then a one-word frame restarts at address 0.
        do_reset(1'b0, "tmid");
        frame.delete();
        add_word(32'd3); add_word($urandom);
        for (int i = 0; i < 6; i++) send_byte(frame[i], 1);
        idle(2);
        do_reset(1'b0, "tmid2");
        frame.delete();
        add_word(32'd1); add_word($urandom);
        run_frame(1'b0, 3, 5, "tmid");

        // Oversized length on the small ROM.
        do_reset(1'b1, "terr");
        frame.delete();
        add_word(32'd5);
        run_frame(1'b1, 0, 12, "terr");

        // Length equal to capacity, back-to-back bytes.
        do_reset(1'b1, "tfull");
        frame.delete();
        add_word(32'd4);
        for (int i = 0; i < 4; i++) add_word($urandom);
        run_frame(1'b1, 0, 8, "tfull");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
